pipe_stage_skid_reg: RTL and testbench

Parametrised elastic pipeline register for the inter-stage boundaries of the pipelined MIPS core (IF/ID, ID/EXE, EXE/MEM, MEM/WB). It carries a DATA_W-bit payload and a CTRL_W-bit control field (WB_en, MEM_R_EN, MEM_W_EN and similar) across one stage. It uses a valid/ready handshake with a two-entry skid buffer, so `in_ready` is a pure register output and stalls never form a combinational path back up the pipe. A synchronous flush kills in-flight instructions by zeroing their control bits, so a flushed slot is a bubble.

---
 rtl/pipe_stage_skid_reg_if.sv | 27 ++
 rtl/pipe_stage_skid_reg.sv | 110 +++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_reg_if.sv
// Handshake bundle for one elastic pipeline boundary: upstream beat in, head beat out.
// The slave modport is the stage itself; master is the surrounding pipeline.
interface pipe_stage_skid_reg_if #(
  parameter int unsigned DATA_W = 101,
  parameter int unsigned CTRL_W = 3
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  modport slave (
    input  flush, in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, occupancy
  );

  modport master (
    output flush, in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, occupancy
  );
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Elastic inter-stage register with a two-entry skid buffer; every output is a flop.
// Empty or flushed slots carry zero ctrl so downstream sees a bubble.
module pipe_stage_skid_reg #(
  parameter int unsigned DATA_W = 101,
  parameter int unsigned CTRL_W = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  pipe_stage_skid_reg_if.slave      bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              acc, rel;

  assign acc = bus.in_valid & in_ready_q;
  assign rel = out_valid_q & bus.out_ready;

  // Next-state and slot updates; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          main_data_d = bus.in_data;
          main_ctrl_d = bus.in_ctrl;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (acc && rel) begin
          main_data_d = bus.in_data;
          main_ctrl_d = bus.in_ctrl;
        end else if (acc) begin
          skid_data_d = bus.in_data;
          skid_ctrl_d = bus.in_ctrl;
          state_d     = TWO;
        end else if (rel) begin
          main_ctrl_d = '0;
          state_d     = EMPTY;
        end
      end
      TWO: begin
        if (rel) begin
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
          skid_ctrl_d = '0;
          state_d     = ONE;
        end
      end
      default: begin
        main_ctrl_d = '0;
        skid_ctrl_d = '0;
        state_d     = EMPTY;
      end
    endcase

    if (bus.flush) begin
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      state_d     = EMPTY;
    end

    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_data_q;
  assign bus.out_ctrl  = main_ctrl_q;
  assign bus.occupancy = 2'(state_q);

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg: reset, streaming, backpressure, flush,
// accept-with-release and asynchronous reset, each checked against hand values.
module tb_pipe_stage_skid_reg;
  localparam int unsigned DATA_W = 101;
  localparam int unsigned CTRL_W = 3;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  pipe_stage_skid_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

  pipe_stage_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = clk_en ? ~clk : clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic ov, input logic ir, input logic [1:0] occ);
    chk({tag, ".out_valid"}, 128'(bus.out_valid), 128'(ov));
    chk({tag, ".in_ready"},  128'(bus.in_ready),  128'(ir));
    chk({tag, ".occupancy"}, 128'(bus.occupancy), 128'(occ));
  endtask

  task automatic offer(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_ctrl  = c;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    offer(1'b0, '0, '0);

    // Reset with the clock stopped
    #2 rst = 1'b0;
    #1;
    chk_state("reset", 1'b0, 1'b1, 2'd0);
    chk("reset.out_data", 128'(bus.out_data), 128'h0);
    chk("reset.out_ctrl", 128'(bus.out_ctrl), 128'h0);
    #5 rst = 1'b1;

    // Single beat
    offer(1'b1, DATA_W'('hABCD), 3'b101);
    bus.out_ready = 1'b1;
    #1 clk_en = 1'b1;
    tick();
    chk_state("single", 1'b1, 1'b1, 2'd1);
    chk("single.out_data", 128'(bus.out_data), 128'hABCD);
    chk("single.out_ctrl", 128'(bus.out_ctrl), 128'h5);

    // Streaming 1..8
    for (int i = 1; i <= 8; i++) begin
      offer(1'b1, DATA_W'(i), 3'b001);
      tick();
      chk($sformatf("stream%0d.out_data", i), 128'(bus.out_data), 128'(i));
      chk($sformatf("stream%0d.in_ready", i), 128'(bus.in_ready), 128'h1);
    end
    offer(1'b0, '0, '0);
    tick();
    chk_state("drain", 1'b0, 1'b1, 2'd0);
    chk("drain.out_ctrl", 128'(bus.out_ctrl), 128'h0);

    // Backpressure with A, B, C
    bus.out_ready = 1'b0;
    offer(1'b1, DATA_W'('hA), 3'b010);
    tick();
    chk_state("bp_a", 1'b1, 1'b1, 2'd1);
    offer(1'b1, DATA_W'('hB), 3'b010);
    tick();
    chk_state("bp_b", 1'b1, 1'b0, 2'd2);
    chk("bp_b.out_data", 128'(bus.out_data), 128'hA);
    offer(1'b1, DATA_W'('hC), 3'b010);
    tick();
    chk_state("bp_c_held", 1'b1, 1'b0, 2'd2);
    chk("bp_c_held.out_data", 128'(bus.out_data), 128'hA);
    bus.out_ready = 1'b1;
    tick();
    chk_state("bp_rel_a", 1'b1, 1'b1, 2'd1);
    chk("bp_rel_a.out_data", 128'(bus.out_data), 128'hB);
    tick();
    chk_state("bp_rel_b", 1'b1, 1'b1, 2'd1);
    chk("bp_rel_b.out_data", 128'(bus.out_data), 128'hC);
    offer(1'b0, '0, '0);
    tick();
    chk_state("bp_drain", 1'b0, 1'b1, 2'd0);

    // Flush while full, with D offered
    bus.out_ready = 1'b0;
    offer(1'b1, DATA_W'('h11), 3'b111);
    tick();
    offer(1'b1, DATA_W'('h22), 3'b111);
    tick();
    chk_state("fl_full", 1'b1, 1'b0, 2'd2);
    chk("fl_full.out_ctrl", 128'(bus.out_ctrl), 128'h7);
    offer(1'b1, DATA_W'('hDD), 3'b111);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    offer(1'b0, '0, '0);
    chk_state("fl_after", 1'b0, 1'b1, 2'd0);
    chk("fl_after.out_ctrl", 128'(bus.out_ctrl), 128'h0);
    bus.out_ready = 1'b1;
    tick();
    chk_state("fl_no_d", 1'b0, 1'b1, 2'd0);

    // Flush drops a beat accepted in the same cycle
    offer(1'b1, DATA_W'('hD0), 3'b111);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    offer(1'b0, '0, '0);
    chk_state("fl_drop", 1'b0, 1'b1, 2'd0);
    chk("fl_drop.out_ctrl", 128'(bus.out_ctrl), 128'h0);

    // Accept and release together in ONE
    offer(1'b1, DATA_W'('hE), 3'b110);
    tick();
    chk("ar_e.out_data", 128'(bus.out_data), 128'hE);
    offer(1'b1, DATA_W'('hF), 3'b011);
    tick();
    chk_state("ar_f", 1'b1, 1'b1, 2'd1);
    chk("ar_f.out_data", 128'(bus.out_data), 128'hF);
    chk("ar_f.out_ctrl", 128'(bus.out_ctrl), 128'h3);
    offer(1'b0, '0, '0);
    tick();
    chk_state("ar_drain", 1'b0, 1'b1, 2'd0);

    // Asynchronous reset while full
    bus.out_ready = 1'b0;
    offer(1'b1, DATA_W'('h31), 3'b111);
    tick();
    offer(1'b1, DATA_W'('h32), 3'b111);
    tick();
    offer(1'b0, '0, '0);
    chk_state("ar2_full", 1'b1, 1'b0, 2'd2);
    #2 rst = 1'b0;
    #1;
    chk_state("async_rst", 1'b0, 1'b1, 2'd0);
    chk("async_rst.out_ctrl", 128'(bus.out_ctrl), 128'h0);
    chk("async_rst.out_data", 128'(bus.out_data), 128'h0);
    #1 rst = 1'b1;
    tick();
    chk_state("post_rst", 1'b0, 1'b1, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
